seq_encoder_4x2: RTL
====================

SEQ_ENCODER_4X2 -- requirements
Module: seq_encoder_4x2

Interface
REQ-001 SHALL have parameter HI_FIRST, default 1, meaning 1 = bit 3 is highest priority and 0 = bit 0 is highest.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: block enable; when low, the block accepts no loads and drives no output.
REQ-005 SHALL have port d, input, 4 bits: request lines, multi-hot allowed.
REQ-006 SHALL have port load, input, 1 bit: strobe that samples d.
REQ-007 SHALL have port clr, input, 1 bit: synchronous flush of all pending requests.
REQ-008 SHALL have port i, output, 2 bits: encoded index of the current highest-priority pending request.
REQ-009 SHALL have port valid, output, 1 bit: i is meaningful.
REQ-010 SHALL have port ready, input, 1 bit: consumer accepts i.
REQ-011 SHALL have port count, output, 3 bits: number of pending request bits (0..4).

Function
REQ-012 SHALL hold a 4-bit pending register pend and a 2-state FSM: IDLE (pend==0) and DRAIN (pend!=0).
REQ-013 SHALL perform a transfer on any rising edge where valid && ready are both high; the transfer consumes the bit indexed by i.
REQ-014 SHALL compute next pend, on an edge with en high and clr low, as (pend & ~consumed) | (load ? d : 4'b0000).
REQ-015 SHALL keep a re-requested bit pending when load sets the same bit that is being consumed on that edge (load wins).
REQ-016 SHALL transition IDLE->DRAIN when the next pend is nonzero, and DRAIN->IDLE when the next pend is zero.
REQ-017 SHALL treat load with d=4'b0000 as a no-op; the FSM stays in its current state.
REQ-018 SHALL assert valid in the cycle after the edge that samples a nonzero load (latency 1), and SHALL NOT combinationally forward d.
REQ-019 SHALL drive valid = en && (pend != 0).
REQ-020 SHALL drive i from pend only, via a priority encode per HI_FIRST.
REQ-021 SHALL drive i = 2'b00 whenever valid is low.
REQ-022 SHALL hold i stable while valid && !ready (no reordering during backpressure); a new load of higher priority MAY change i only after an edge with no pending stall, so loads during a stall merge into pend but i is recomputed only after the transfer.
REQ-023 SHALL drive count = popcount(pend), zero-extended to 3 bits, with no overflow possible.
REQ-024 SHALL, when en is low, ignore load, clr and ready, force valid low, and retain pend.
REQ-025 SHALL, when en and clr are both high, set pend to 0 and enter IDLE; clr takes precedence over load and transfer on the same edge.
REQ-026 SHALL, when HI_FIRST=1 and pend=4'b1010, drain i=3 then i=1; when HI_FIRST=0, drain i=1 then i=3.

Reset
REQ-027 SHALL, when rst_n goes low, immediately (without a clock edge) force pend=0, FSM=IDLE, valid=0, i=2'b00, count=3'b000.
REQ-028 SHALL discard any in-progress drain on a reset mid-operation; after release, no output until a new load.
REQ-029 SHALL sample no input on the first edge coincident with rst_n release, which is treated as still-in-reset.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, DRAIN) and the width constants (4 request lines, 2-bit code) in shared package enc_dec_pkg, for reuse by decoder2x4-family blocks.
REQ-031 SHALL instantiate one sub-module, prio_enc4 (combinational 4->2 priority encoder with HI_FIRST parameter and any-bit flag); all remaining logic (register, FSM, popcount) SHALL live in seq_encoder_4x2.

Verification
REQ-032 SHALL cover: en=1, load d=4'b0100, ready=1 -> next cycle valid=1, i=2; following cycle valid=0, count=0.
REQ-033 SHALL cover: load d=4'b1011, ready=1, HI_FIRST=1 -> i sequence 3,1,0 on consecutive cycles, count 3,2,1, then valid=0.
REQ-034 SHALL cover: pend=4'b0011, ready=0 for 3 cycles -> i=1 held, valid=1; load d=4'b1000 during the stall -> count=3, and after ready=1 the order is 1,3,0.
REQ-035 SHALL cover: transfer of i=2 with simultaneous load d=4'b0100 -> bit 2 remains pending, count unchanged.
REQ-036 SHALL cover: en=0 with load d=4'b1111 -> pend unchanged and valid=0; re-assert en -> the prior pending bits reappear.
REQ-037 SHALL cover: rst_n pulsed low mid-drain (pend=4'b0110) -> valid=0, count=0 asynchronously; clr with load on the same edge -> pend=0.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// enc_dec_pkg: shared widths and FSM encoding for the encoder/decoder family.
package enc_dec_pkg;
    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
endpackage

// File: rtl/prio_enc4.sv
// prio_enc4: combinational 4->2 priority encoder with selectable priority order.
module prio_enc4
    import enc_dec_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic [N_REQ-1:0]  d,
    output logic [CODE_W-1:0] i,
    output logic              any
);
    always_comb begin
        i = HI_FIRST ? (d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0)
                     : (d[0] ? 2'd0 : d[1] ? 2'd1 : d[2] ? 2'd2 : d[3] ? 2'd3 : 2'd0);
        any = |d;
    end
endmodule

// File: rtl/seq_encoder_4x2.sv
// seq_encoder_4x2: pending-request register drained one index per transfer
// in priority order, with a held index during consumer backpressure.
module seq_encoder_4x2
    import enc_dec_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_REQ-1:0]  d,
    input  logic              load,
    input  logic              clr,
    output logic [CODE_W-1:0] i,
    output logic              valid,
    input  logic              ready,
    output logic [2:0]        count
);
    logic [N_REQ-1:0]  pend, pend_nxt, consumed;
    logic [0:0]        state;
    logic [CODE_W-1:0] enc, held;
    logic              any, locked, armed, act, xfer, stall;

    prio_enc4 #(.HI_FIRST(HI_FIRST)) u_enc (.d(pend), .i(enc), .any(any));

    // Once an index has been presented and stalled, it is frozen until taken.
    assign valid = en && any && (state == DRAIN);
    assign i     = valid ? (locked ? held : enc) : '0;
    assign xfer  = valid && ready;
    assign stall = valid && !ready;
    assign act   = en && armed;
    assign count = 3'(pend[0]) + 3'(pend[1]) + 3'(pend[2]) + 3'(pend[3]);

    always_comb begin
        consumed = xfer ? (N_REQ'(1) << i) : '0;
        pend_nxt = clr ? '0 : (pend & ~consumed) | (load ? d : '0);
    end

    // armed keeps the first edge after reset release from sampling inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            state  <= IDLE;
            locked <= 1'b0;
            held   <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (act) begin
                pend   <= pend_nxt;
                state  <= (pend_nxt != '0) ? DRAIN : IDLE;
                locked <= !clr && stall;
                if (stall) held <= i;
            end
        end
    end
endmodule
